udp_tx_hdr_insert: RTL and testbench



---
 rtl/udp_tx_hdr_insert.sv | 176 +++++++++++++++++
 tb/tb_udp_tx_hdr_insert.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_hdr_insert.sv
// Store-and-forward UDP header patcher: holds each frame until its length/checksum word arrives, then
// replays it with header bytes 4..7 replaced. Define UDP_TX_CSUM_EN to insert the checksum (else 0x0000).
module udp_tx_hdr_insert #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int BUF_DEPTH      = 2048,
  parameter int META_DEPTH     = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [AXI_DATA_WIDTH-1:0] s_tx_axis_tdata,
  input  logic                      s_tx_axis_tvalid,
  input  logic                      s_tx_axis_tlast,
  output logic                      s_tx_axis_trdy,
  input  logic                      s_udp_tx_hdr_valid,
  input  logic [15:0]               s_udp_tx_length,
  input  logic [15:0]               s_udp_tx_checksum,
  output logic                      s_udp_tx_hdr_trdy,
  output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
  output logic                      m_tx_axis_tvalid,
  output logic                      m_tx_axis_tlast,
  input  logic                      m_tx_axis_trdy,
  output logic                      o_len_mismatch
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int MW = $clog2(META_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} state_t;

  logic [DW:0]    buf_mem [BUF_DEPTH];
  logic [31:0]    meta_mem [META_DEPTH];
  logic [DW:0]    ram_dout_q;
  logic [AW-1:0]  rd_addr;

  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    commit_cnt_q, commit_cnt_d;
  logic [MW:0]    meta_wr_q, meta_wr_d, meta_rd_q, meta_rd_d, meta_used;
  state_t         state_q, state_d;
  logic [15:0]    idx_q, idx_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic           mismatch_q, mismatch_d;
  logic           in_trdy_q, hdr_trdy_q;
  logic           buf_full_d, meta_full_d;

  logic           wr_fire, commit, meta_push, out_take, frame_done, load;
  logic [15:0]    hd_len, hd_csum, csum_ins;

  function automatic logic [DW-1:0] patch_byte(input logic [DW-1:0] b, input logic [15:0] i,
                                               input logic [15:0] len, input logic [15:0] csum);
    case (i)
      16'd4:   return DW'(len[15:8]);
      16'd5:   return DW'(len[7:0]);
      16'd6:   return DW'(csum[15:8]);
      16'd7:   return DW'(csum[7:0]);
      default: return b;
    endcase
  endfunction

  assign wr_fire    = s_tx_axis_tvalid & in_trdy_q;
  assign commit     = wr_fire & s_tx_axis_tlast;
  assign meta_push  = s_udp_tx_hdr_valid & hdr_trdy_q;
  assign out_take   = out_valid_q & m_tx_axis_trdy;
  assign frame_done = out_take & out_last_q;
  assign meta_used  = meta_wr_q - meta_rd_q;
  assign hd_len     = meta_mem[meta_rd_q[MW-1:0]][31:16];
  assign hd_csum    = meta_mem[meta_rd_q[MW-1:0]][15:0];

`ifdef UDP_TX_CSUM_EN
  // A computed checksum of zero must go out as all-ones; zero on the wire means "no checksum".
  assign csum_ins = (hd_csum == 16'h0000) ? 16'hFFFF : hd_csum;
`else
  logic unused_csum;
  assign unused_csum = ^hd_csum;
  assign csum_ins    = 16'h0000;
`endif

  assign wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, wr_fire};
  assign commit_cnt_d = commit_cnt_q + {{AW{1'b0}}, commit} - {{AW{1'b0}}, frame_done};
  assign meta_wr_d    = meta_wr_q + {{MW{1'b0}}, meta_push};
  assign meta_rd_d    = meta_rd_q + {{MW{1'b0}}, frame_done};
  assign buf_full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign meta_full_d  = (meta_wr_d[MW] != meta_rd_d[MW]) && (meta_wr_d[MW-1:0] == meta_rd_d[MW-1:0]);

  // The RAM register re-reads the same address while the output stalls, so it doubles as the skid slot.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    mismatch_d  = 1'b0;
    load        = 1'b0;
    rd_addr     = rd_ptr_q[AW-1:0];
    unique case (state_q)
      ST_IDLE:   if (commit_cnt_q != '0 && meta_used != '0) state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (frame_done) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          mismatch_d  = (idx_q + 16'd1) != hd_len;
          state_d     = (commit_cnt_q >= (AW+1)'(2) && meta_used >= (MW+1)'(2)) ? ST_LOAD : ST_IDLE;
        end else if (out_take) begin
          load = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (load) begin
      idx_d       = (state_q == ST_LOAD) ? 16'd0 : idx_q + 16'd1;
      out_valid_d = 1'b1;
      out_last_d  = ram_dout_q[DW];
      out_data_d  = patch_byte(ram_dout_q[DW-1:0], idx_d, hd_len, csum_ins);
      rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      rd_addr     = rd_ptr_d[AW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_cnt_q <= '0;
      meta_wr_q    <= '0;
      meta_rd_q    <= '0;
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      mismatch_q   <= 1'b0;
      in_trdy_q    <= 1'b0;
      hdr_trdy_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_cnt_q <= commit_cnt_d;
      meta_wr_q    <= meta_wr_d;
      meta_rd_q    <= meta_rd_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      mismatch_q   <= mismatch_d;
      in_trdy_q    <= !buf_full_d;
      hdr_trdy_q   <= !meta_full_d;
    end
  end

  // NOTE: storage arrays are not reset; clearing the pointers is enough to make their contents unreachable.
  always_ff @(posedge i_clk) begin
    if (wr_fire) buf_mem[wr_ptr_q[AW-1:0]] <= {s_tx_axis_tlast, s_tx_axis_tdata};
    ram_dout_q <= buf_mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (meta_push) meta_mem[meta_wr_q[MW-1:0]] <= {s_udp_tx_length, s_udp_tx_checksum};
  end

  assign s_tx_axis_trdy    = in_trdy_q;
  assign s_udp_tx_hdr_trdy = hdr_trdy_q;
  assign m_tx_axis_tdata   = out_data_q;
  assign m_tx_axis_tvalid  = out_valid_q;
  assign m_tx_axis_tlast   = out_last_q;
  assign o_len_mismatch    = mismatch_q;

endmodule

// File: tb/tb_udp_tx_hdr_insert.sv
// Directed bench for udp_tx_hdr_insert: a table of single frames plus hand-written multi-frame,
// stall and reset sequences. Expected checksum bytes follow UDP_TX_CSUM_EN.
module tb_udp_tx_hdr_insert;

`ifdef UDP_TX_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  s_tx_axis_tdata;
  logic        s_tx_axis_tvalid, s_tx_axis_tlast, s_tx_axis_trdy;
  logic        s_udp_tx_hdr_valid, s_udp_tx_hdr_trdy;
  logic [15:0] s_udp_tx_length, s_udp_tx_checksum;
  logic [7:0]  m_tx_axis_tdata;
  logic        m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_trdy;
  logic        o_len_mismatch;

  udp_tx_hdr_insert dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .s_tx_axis_tdata    (s_tx_axis_tdata),
    .s_tx_axis_tvalid   (s_tx_axis_tvalid),
    .s_tx_axis_tlast    (s_tx_axis_tlast),
    .s_tx_axis_trdy     (s_tx_axis_trdy),
    .s_udp_tx_hdr_valid (s_udp_tx_hdr_valid),
    .s_udp_tx_length    (s_udp_tx_length),
    .s_udp_tx_checksum  (s_udp_tx_checksum),
    .s_udp_tx_hdr_trdy  (s_udp_tx_hdr_trdy),
    .m_tx_axis_tdata    (m_tx_axis_tdata),
    .m_tx_axis_tvalid   (m_tx_axis_tvalid),
    .m_tx_axis_tlast    (m_tx_axis_tlast),
    .m_tx_axis_trdy     (m_tx_axis_trdy),
    .o_len_mismatch     (o_len_mismatch)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          len;
    logic [7:0]  seed;
    logic [15:0] mlen;
    logic [15:0] mcsum;
    logic [7:0]  b4, b5, b6, b7;
    int          exp_mm;
  } vec_t;

  vec_t       vecs [7];
  logic [8:0] exp_q [$];
  logic [8:0] obs_q [$];
  int         n_vec = 0, n_fail = 0;
  int         exp_mm = 0, mm_cnt = 0, stall_err = 0, bubble_cnt = 0;
  bit         rand_trdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input logic [7:0] seed, input int k);
    if (k < 8) return 8'hF0 + 8'(k);
    return seed + 8'(8'h11 * (k - 8));
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] seed, input int k,
                                            input logic [15:0] ml, input logic [15:0] mc);
    logic [15:0] ce;
    ce = CSUM_EN ? ((mc == 16'h0000) ? 16'hFFFF : mc) : 16'h0000;
    case (k)
      4:       return ml[15:8];
      5:       return ml[7:0];
      6:       return ce[15:8];
      7:       return ce[7:0];
      default: return gen_byte(seed, k);
    endcase
  endfunction

  task automatic push_exp(input int len, input logic [7:0] seed, input logic [15:0] ml, input logic [15:0] mc);
    for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, model_byte(seed, k, ml, mc)});
    if (len != int'(ml)) exp_mm++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Output monitor: samples on the falling edge, checks hold-while-stalled and intra-frame bubbles.
  logic [8:0] held;
  bit         stall_prev = 1'b0, take_prev = 1'b0;
  always @(negedge i_clk) begin
    if (i_reset) begin
      stall_prev = 1'b0;
      take_prev  = 1'b0;
    end else begin
      if (stall_prev && !(m_tx_axis_tvalid && {m_tx_axis_tlast, m_tx_axis_tdata} == held)) stall_err++;
      if (take_prev && !m_tx_axis_tvalid) bubble_cnt++;
      if (m_tx_axis_tvalid && m_tx_axis_trdy) obs_q.push_back({m_tx_axis_tlast, m_tx_axis_tdata});
      if (o_len_mismatch) mm_cnt++;
      stall_prev = m_tx_axis_tvalid && !m_tx_axis_trdy;
      held       = {m_tx_axis_tlast, m_tx_axis_tdata};
      take_prev  = m_tx_axis_tvalid && m_tx_axis_trdy && !m_tx_axis_tlast;
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rand_trdy) m_tx_axis_trdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_frame(input int len, input logic [7:0] seed, input bit with_last);
    for (int k = 0; k < len; k++) begin
      bit ok = 1'b0;
      s_tx_axis_tvalid = 1'b1;
      s_tx_axis_tdata  = gen_byte(seed, k);
      s_tx_axis_tlast  = with_last && (k == len - 1);
      for (int c = 0; c < 4000 && !ok; c++) begin
        @(negedge i_clk);
        ok = s_tx_axis_trdy;
        tick();
      end
      if (!ok) check("write handshake", 32'(ok), 32'd1);
    end
    s_tx_axis_tvalid = 1'b0;
    s_tx_axis_tlast  = 1'b0;
  endtask

  task automatic send_meta(input logic [15:0] ml, input logic [15:0] mc);
    bit ok = 1'b0;
    s_udp_tx_hdr_valid = 1'b1;
    s_udp_tx_length    = ml;
    s_udp_tx_checksum  = mc;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge i_clk);
      ok = s_udp_tx_hdr_trdy;
      tick();
    end
    if (!ok) check("meta handshake", 32'(ok), 32'd1);
    s_udp_tx_hdr_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    for (int c = 0; c < budget && obs_q.size() < exp_q.size(); c++) @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    check({tag, " byte count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s byte %0d {last,data}", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, " len_mismatch pulses"}, 32'(mm_cnt), 32'(exp_mm));
    obs_q.delete();
    exp_q.delete();
    mm_cnt = 0;
    exp_mm = 0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    vecs[0] = '{12, 8'hAA, 16'h000C, 16'h1234, 8'h00, 8'h0C, CSUM_EN ? 8'h12 : 8'h00, CSUM_EN ? 8'h34 : 8'h00, 0};
    vecs[1] = '{12, 8'h01, 16'h0010, 16'hABCD, 8'h00, 8'h10, CSUM_EN ? 8'hAB : 8'h00, CSUM_EN ? 8'hCD : 8'h00, 1};
    vecs[2] = '{ 8, 8'h5A, 16'h0008, 16'h0000, 8'h00, 8'h08, CSUM_EN ? 8'hFF : 8'h00, CSUM_EN ? 8'hFF : 8'h00, 0};
    vecs[3] = '{ 5, 8'h33, 16'h0008, 16'h5678, 8'h00, 8'h00, 8'h00, 8'h00, 1};
    vecs[4] = '{ 3, 8'h77, 16'h0103, 16'h1111, 8'h00, 8'h00, 8'h00, 8'h00, 1};
    vecs[5] = '{20, 8'hC0, 16'h0014, 16'h8001, 8'h00, 8'h14, CSUM_EN ? 8'h80 : 8'h00, CSUM_EN ? 8'h01 : 8'h00, 0};
    vecs[6] = '{ 9, 8'h0F, 16'hFF09, 16'h0000, 8'hFF, 8'h09, CSUM_EN ? 8'hFF : 8'h00, CSUM_EN ? 8'hFF : 8'h00, 1};

    i_reset = 1'b1;
    s_tx_axis_tdata = '0; s_tx_axis_tvalid = 1'b0; s_tx_axis_tlast = 1'b0;
    s_udp_tx_hdr_valid = 1'b0; s_udp_tx_length = '0; s_udp_tx_checksum = '0;
    m_tx_axis_trdy = 1'b1;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset m_tvalid", 32'(m_tx_axis_tvalid), 32'd0);
    check("reset m_tlast", 32'(m_tx_axis_tlast), 32'd0);
    check("reset m_tdata", 32'(m_tx_axis_tdata), 32'd0);
    check("reset len_mismatch", 32'(o_len_mismatch), 32'd0);
    check("reset s_trdy", 32'(s_tx_axis_trdy), 32'd0);
    check("reset hdr_trdy", 32'(s_udp_tx_hdr_trdy), 32'd0);
    tick();
    i_reset = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("post-reset s_trdy", 32'(s_tx_axis_trdy), 32'd1);
    check("post-reset hdr_trdy", 32'(s_udp_tx_hdr_trdy), 32'd1);
    tick();

    // Single-frame table: meta first, then the frame, output always ready.
    foreach (vecs[v]) begin
      send_meta(vecs[v].mlen, vecs[v].mcsum);
      send_frame(vecs[v].len, vecs[v].seed, 1'b1);
      if (v == 0) begin
        found = 1'b0;
        for (int c = 0; c < 3 && !found; c++) begin
          @(negedge i_clk);
          found = m_tx_axis_tvalid;
        end
        check("first-byte latency <= 3", 32'(found), 32'd1);
      end
      for (int k = 0; k < vecs[v].len; k++) begin
        logic [7:0] d;
        case (k)
          4:       d = vecs[v].b4;
          5:       d = vecs[v].b5;
          6:       d = vecs[v].b6;
          7:       d = vecs[v].b7;
          default: d = gen_byte(vecs[v].seed, k);
        endcase
        exp_q.push_back({k == vecs[v].len - 1, d});
      end
      exp_mm = vecs[v].exp_mm;
      drain($sformatf("vec%0d", v), 200);
    end

    // Early meta, then three back-to-back frames with meta trailing each tlast.
    send_meta(16'h000C, 16'h1111);
    repeat (20) tick();
    send_frame(12, 8'h21, 1'b1);
    push_exp(12, 8'h21, 16'h000C, 16'h1111);
    send_frame(16, 8'h42, 1'b1);
    send_meta(16'h0010, 16'h2222);
    push_exp(16, 8'h42, 16'h0010, 16'h2222);
    send_frame(10, 8'h63, 1'b1);
    send_meta(16'h000A, 16'h0000);
    push_exp(10, 8'h63, 16'h000A, 16'h0000);
    drain("seq3", 400);

    // Maximum payload with a randomly stalling sink.
    send_meta(16'h05C8, 16'h9ABC);
    rand_trdy = 1'b1;
    send_frame(1480, 8'h37, 1'b1);
    push_exp(1480, 8'h37, 16'h05C8, 16'h9ABC);
    drain("max_stall", 10000);
    rand_trdy = 1'b0;
    tick();
    m_tx_axis_trdy = 1'b1;
    tick();

    // Reset with a committed-but-unpaired frame and a partial frame in the buffer.
    send_frame(6, 8'h44, 1'b1);
    send_frame(5, 8'h55, 1'b0);
    i_reset = 1'b1;
    tick();
    @(negedge i_clk);
    check("mid reset s_trdy", 32'(s_tx_axis_trdy), 32'd0);
    check("mid reset hdr_trdy", 32'(s_udp_tx_hdr_trdy), 32'd0);
    check("mid reset m_tvalid", 32'(m_tx_axis_tvalid), 32'd0);
    tick();
    i_reset = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("release s_trdy", 32'(s_tx_axis_trdy), 32'd1);
    check("release hdr_trdy", 32'(s_udp_tx_hdr_trdy), 32'd1);
    tick();
    send_meta(16'h000A, 16'h4321);
    send_frame(10, 8'h66, 1'b1);
    push_exp(10, 8'h66, 16'h000A, 16'h4321);
    drain("after_reset", 200);

    check("data stable while stalled", 32'(stall_err), 32'd0);
    check("no intra-frame bubbles", 32'(bubble_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
